rr_mux_nx1: RTL and testbench
=============================

# rr_mux_nx1

Parametrised N-to-1 data multiplexer with registered output, valid/ready handshaking and round-robin channel selection. It replaces the combinational 2:1 select mux where several producers share one downstream consumer and must not lose data. It sits between N upstream stream sources and one downstream sink in the same clock domain.

## Interface

Parameters:
- N, 4, number of input channels; legal range 2..16.
- W, 8, data width per channel in bits; at least 1.
- SW, $clog2(N), width of the channel index; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  bit i set when channel i presents a beat.
- in_data  input  N*W  channel i data on bits [i*W +: W].
- in_ready  output  N  one-hot or zero; bit i set means channel i's beat is taken this cycle.
- in_last  input  N  end-of-packet marker per channel. Present only when MUX_LOCK_EN is defined.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered data.
- out_sel  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  sink accepts the beat when out_valid is high.

## Operation

- **Single-entry output register.** `space = !out_valid || out_ready`.
- **Grant.** When `space` is 1, the first channel with in_valid set, searching upward modulo N from `ptr+1`, is granted. `ptr` is the last granted index.
  - `in_ready[g] = space` for the granted channel g. All other bits of in_ready are 0.
  - in_ready is combinational from in_valid, out_ready and state.
  - No grant is made when in_valid is 0.
- **Transfer.** A transfer occurs when `in_valid[g] && in_ready[g]`. On the next clock edge:
  - out_data ← the channel's data;
  - out_sel ← g;
  - out_valid ← 1;
  - ptr ← g.
- **Drain.** If `out_valid && out_ready` and no transfer occurs, out_valid ← 0.
  - out_data and out_sel hold their last values.
- **Simultaneous drain and fill.** Drain and fill in the same cycle gives back-to-back beats with no bubble.
- **Stall.** While `out_valid && !out_ready`:
  - out_data and out_sel are held stable;
  - in_ready is all zero.
- **Fairness.** With all N channels continuously valid and the sink always ready, grants rotate 0,1,…,N-1,0,…. Each channel is served once per N beats.
- **Reset.**
  - Reset values: out_valid=0, out_data=0, out_sel=0, ptr=N-1, so channel 0 is served first.
  - In lock builds, the lock state returns to IDLE.
  - Reset asserted mid-stream discards the held beat immediately (asynchronous).
  - in_ready is 0 while rst_n is low.

## Timing

- Latency is 1 cycle from input handshake to out_valid.
- Throughput is 1 beat per cycle sustained.
- out_ready → in_ready is a combinational path. The sink must not derive out_ready from in_ready.
- All state updates on the rising edge of clk. Reset is asynchronous assert and synchronous release by the system.

## Configuration

- **MUX_LOCK_EN undefined.** Arbitration is performed every beat. The in_last port does not exist.
- **MUX_LOCK_EN defined.** The in_last port is added and a two-state FSM is present.
  - IDLE: arbitrate normally. A transfer with `in_last[g]=0` moves to LOCK with lock index g.
  - LOCK: only the locked channel can be granted, regardless of other in_valid bits.
    - in_ready for the locked channel = `space`.
    - A transfer with `in_last=1` returns to IDLE and sets ptr ← g.
    - Locked-channel idle cycles (in_valid low) keep LOCK.
  - A single-beat packet (in_last=1 on the first beat) never enters LOCK.

## Test plan

Run with N=4, W=8.

1. **Reset.** Hold rst_n=0 with all in_valid=1 → out_valid=0, out_data=0x00, out_sel=0, in_ready=0000. Release with data 0x10,0x11,0x12,0x13 and out_ready=1 → out_data sequence 0x10,0x11,0x12,0x13,0x10 on consecutive cycles, with out_sel 0,1,2,3,0.
2. **Sparse requesters.** Only channels 1 and 3 valid, out_ready=1 → grants alternate 1,3,1,3. in_ready[0] and in_ready[2] never assert.
3. **Backpressure.** Channel 2 sends 0xA5, then out_ready=0 for 5 cycles with all channels valid → out_data stays 0xA5, out_sel=2, in_ready=0000 throughout. The first cycle with out_ready=1 grants channel 3.
4. **Drain to empty.** Single beat 0x3C on channel 0, out_ready=1, then in_valid=0 → out_valid is high for exactly 1 cycle, then 0. out_data stays 0x3C.
5. **Reset mid-stream.** rst_n pulsed low while out_valid=1 and out_ready=0 → out_valid drops immediately without waiting for a clock. After release, channel 0 is granted first.
6. **Packet lock (MUX_LOCK_EN).** Channel 1 sends a 3-beat packet 0x01,0x02,0x03 (in_last on the third beat) while channels 0, 2 and 3 are valid → three consecutive beats are from channel 1, then channel 2 is granted. Without the macro, the same stimulus interleaves 1,2,3,0.

Source files
------------

// File: rtl/rr_mux_nx1.sv
// N-to-1 round-robin stream mux with a single registered output slot and valid/ready on both sides.
// Define MUX_LOCK_EN to add in_last and keep the grant on one channel for a whole packet.
module rr_mux_nx1 #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
`ifdef MUX_LOCK_EN
    input  logic [N-1:0]   in_last,
`endif
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic [N-1:0][W-1:0] data_v;
    assign data_v = in_data;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_sel_q,   out_sel_d;
    logic [SW-1:0] ptr_q,       ptr_d;

    logic          space;
    logic          xfer;
    logic [N-1:0]  req;
    logic          gnt_found;
    logic          hi_found;
    logic [SW-1:0] hi_idx;
    logic [SW-1:0] lo_idx;
    logic [SW-1:0] gnt_idx;

    assign space = !out_valid_q || out_ready;

`ifdef MUX_LOCK_EN
    typedef enum logic {IDLE, LOCK} lock_state_e;
    lock_state_e   state_q;
    logic [SW-1:0] lock_idx_q;

    // While locked, every channel but the packet owner is masked out.
    always_comb begin
        req = in_valid;
        if (state_q == LOCK) begin
            for (int i = 0; i < N; i++) begin
                req[i] = in_valid[i] && (SW'(i) == lock_idx_q);
            end
        end
    end
`else
    assign req = in_valid;
`endif

    // Two-pass priority: lowest requester above ptr wins, else lowest requester overall.
    always_comb begin
        hi_found  = 1'b0;
        hi_idx    = '0;
        gnt_found = 1'b0;
        lo_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_found = 1'b1;
                lo_idx    = SW'(i);
                if (SW'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = SW'(i);
                end
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

    assign xfer = space && gnt_found;

    for (genvar i = 0; i < N; i++) begin : g_rdy
        assign in_ready[i] = rst_n && xfer && (gnt_idx == SW'(i));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = data_v[gnt_idx];
            out_sel_d   = gnt_idx;
            ptr_d       = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= SW'(N - 1);
`ifdef MUX_LOCK_EN
            state_q     <= IDLE;
            lock_idx_q  <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef MUX_LOCK_EN
            if (xfer) begin
                case (state_q)
                    IDLE: if (!in_last[gnt_idx]) begin
                        state_q    <= LOCK;
                        lock_idx_q <= gnt_idx;
                    end
                    LOCK: if (in_last[gnt_idx]) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Self-checking bench for rr_mux_nx1 (N=4, W=8): directed scenarios plus randomized traffic vs a behavioural model.
`timescale 1ns/1ps
module tb_rr_mux_nx1;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    // Behavioural reference state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;
    bit           m_lock;
    int           m_lidx;

    rr_mux_nx1 #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = N - 1;
        m_lock  = 1'b0;
        m_lidx  = 0;
    endtask

    // Channel granted this cycle, or -1 when nothing moves.
    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        if (m_lock) return in_valid[SW'(m_lidx)] ? m_lidx : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[SW'(c)]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        int g;
        g = exp_grant();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    // Advance one clock edge and update the model from the pre-edge inputs.
    task automatic tick();
        int           g;
        logic [W-1:0] d;
        logic         lst;
        logic         rdy;
        d   = '0;
        lst = 1'b0;
        g   = exp_grant();
        rdy = out_ready;
        if (g >= 0) begin
            d   = in_data[g*W +: W];
            lst = in_last[SW'(g)];
        end
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = d;
            m_sel   = g;
            m_ptr   = g;
`ifdef MUX_LOCK_EN
            if (!m_lock && !lst) begin
                m_lock = 1'b1;
                m_lidx = g;
            end else if (m_lock && lst) begin
                m_lock = 1'b0;
            end
`endif
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_seq_valid[%0d]: got %b want 1", k, out_valid); end
            total++; if (out_data !== 8'(8'h10 + k % 4)) begin bad++; $display("FAIL reset_seq_data[%0d]: got %h want %h", k, out_data, 8'(8'h10 + k % 4)); end
            total++; if (out_sel !== SW'(k % 4)) begin bad++; $display("FAIL reset_seq_sel[%0d]: got %0d want %0d", k, out_sel, k % 4); end
        end
    endtask

    task automatic test_sparse();
        in_valid  = 4'b1010;
        in_data   = {8'h23, 8'h22, 8'h21, 8'h20};
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++; if ((in_ready & 4'b0101) !== 4'b0000) begin bad++; $display("FAIL sparse_idle_ready[%0d]: got %b want x0x0", k, in_ready); end
            total++; if (in_ready !== exp_rdy()) begin bad++; $display("FAIL sparse_ready[%0d]: got %b want %b", k, in_ready, exp_rdy()); end
            tick();
            total++; if (out_sel !== SW'((k % 2 == 0) ? 1 : 3)) begin bad++; $display("FAIL sparse_sel[%0d]: got %0d want %0d", k, out_sel, (k % 2 == 0) ? 1 : 3); end
            total++; if (out_data !== m_data) begin bad++; $display("FAIL sparse_data[%0d]: got %h want %h", k, out_data, m_data); end
        end
    endtask

    task automatic test_backpressure();
        in_valid  = 4'b0100;
        in_data   = {8'hB3, 8'hA5, 8'hB1, 8'hB0};
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_load_ready: got %b want 0100", in_ready); end
        tick();
        total++; if (out_data !== 8'hA5 || out_sel !== 2'd2) begin bad++; $display("FAIL bp_load: got %h/%0d want a5/2", out_data, out_sel); end
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", k, in_ready); end
            total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
                bad++; $display("FAIL bp_stall_hold[%0d]: got %b/%h/%0d want 1/a5/2", k, out_valid, out_data, out_sel);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_ready: got %b want 1000", in_ready); end
        tick();
        total++; if (out_sel !== 2'd3 || out_data !== 8'hB3) begin bad++; $display("FAIL bp_release_out: got %0d/%h want 3/b3", out_sel, out_data); end
    endtask

    task automatic test_drain();
        in_valid  = 4'b0001;
        in_data   = {8'h00, 8'h00, 8'h00, 8'h3C};
        out_ready = 1'b1;
        #1;
        tick();
        in_valid = 4'b0000;
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin bad++; $display("FAIL drain_beat: got %b/%h want 1/3c", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", out_valid); end
        total++; if (out_data !== 8'h3C || out_sel !== 2'd0) begin bad++; $display("FAIL drain_hold: got %h/%0d want 3c/0", out_data, out_sel); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_stay_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        in_valid  = 4'b0010;
        in_data   = {8'h63, 8'h62, 8'h5A, 8'h60};
        out_ready = 1'b1;
        #1;
        tick();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        total++; if (out_valid !== 1'b1 || in_ready !== 4'b0000) begin bad++; $display("FAIL midrst_pre: got %b/%b want 1/0000", out_valid, in_ready); end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_async_drop: got %b want 0", out_valid); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready: got %b want 0000", in_ready); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL midrst_first_grant: got %b want 0001", in_ready); end
        tick();
        total++; if (out_sel !== 2'd0 || out_data !== 8'h60) begin bad++; $display("FAIL midrst_first_beat: got %0d/%h want 0/60", out_sel, out_data); end
    endtask

    task automatic test_lock();
        int seq [4];
        int b1;
        logic [W-1:0] want;
`ifdef MUX_LOCK_EN
        seq = '{1, 1, 1, 2};
`else
        seq = '{1, 2, 3, 0};
`endif
        b1        = 0;
        in_valid  = 4'b1111;
        in_data   = {8'hE3, 8'hE2, 8'h01, 8'hE0};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data[W +: W] = 8'(b1 + 1);
            in_last = (b1 == 2) ? 4'b0010 : 4'b0000;
            #1;
            total++; if (in_ready !== exp_rdy()) begin bad++; $display("FAIL lock_ready[%0d]: got %b want %b", k, in_ready, exp_rdy()); end
            want = (seq[k] == 1) ? 8'(b1 + 1) : 8'(8'hE0 + seq[k]);
            tick();
            total++; if (out_sel !== SW'(seq[k])) begin bad++; $display("FAIL lock_sel[%0d]: got %0d want %0d", k, out_sel, seq[k]); end
            total++; if (out_data !== want) begin bad++; $display("FAIL lock_data[%0d]: got %h want %h", k, out_data, want); end
            if (seq[k] == 1) b1++;
        end
        in_last = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = N'($urandom);
            in_data   = $urandom;
            in_last   = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++; if (in_ready !== exp_rdy()) begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, exp_rdy()); end
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, m_valid); end
            total++; if (out_data !== m_data || out_sel !== SW'(m_sel)) begin
                bad++; $display("FAIL rand_out[%0d]: got %h/%0d want %h/%0d", c, out_data, out_sel, m_data, m_sel);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sparse();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
